tff_mod_counter: RTL

Parameterised modulo-M up/down counter built from a bank of toggle cells, one per bit. It computes the per-bit T enables from the current count and the requested next count, and drives a row of T flip-flops. It sits directly upstream of the toggle-cell stage, producing its T inputs, and supplies divided-clock enables and terminal-count strobes to downstream logic.

---
 rtl/tff_mod_counter_pkg.sv | 22 ++
 rtl/tff_mod_counter_if.sv | 34 +++
 rtl/tff_mod_counter_tff.sv | 33 +++
 rtl/tff_mod_counter.sv | 109 ++++++++++
 4 files changed

// File: rtl/tff_mod_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module : tff_mod_counter_pkg
// Brief  : Shared constants and helpers for the toggle-cell modulo counters.
//          DIR_UP / DIR_DOWN : encodings of the counter direction input.
//          modulus_is_legal  : elaboration-time range check of a modulus
//                              against a counter width.
// Rev    : 1.0  initial release
// ============================================================================
package tff_mod_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // A modulus must allow at least two states and must fit in WIDTH bits.
  function automatic bit modulus_is_legal(input int width, input longint modulus);
    if (width < 1 || width > 62) return 1'b0;
    return (modulus >= 2) && (modulus <= (longint'(1) << width));
  endfunction

endpackage
`default_nettype wire

// File: rtl/tff_mod_counter_if.sv
`default_nettype none
// ============================================================================
// Module : tff_mod_counter_if
// Brief  : Control/status bundle of the modulo counter.
//          master : drives en, up, load, load_val; observes the status.
//          slave  : the counter; drives count, count_bar, tc, wrap, err.
// Rev    : 1.0  initial release
// ============================================================================
interface tff_mod_counter_if #(
  parameter int WIDTH = 4
) ();

  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_bar;
  logic             tc;
  logic             wrap;
  logic             err;

  modport master (
    output en, up, load, load_val,
    input  count, count_bar, tc, wrap, err
  );

  modport slave (
    input  en, up, load, load_val,
    output count, count_bar, tc, wrap, err
  );

endinterface
`default_nettype wire

// File: rtl/tff_mod_counter_tff.sv
`default_nettype none
// ============================================================================
// Module : T_flipflop
// Brief  : Single-bit toggle cell with asynchronous active-high reset.
//          clk, reset : clock and asynchronous clear
//          i_t        : toggle enable, q inverts on the edge when high
//          o_q/o_qbar : stored bit and its complement
// Rev    : 1.0  initial release
// ============================================================================
module T_flipflop (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_t,
  output logic      o_q,
  output logic      o_qbar
);

  logic r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= 1'b0;
    end else if (i_t) begin
      r_q <= ~r_q;
    end
  end

  // Complement is derived from the stored bit so it tracks reset as well.
  assign o_q    = r_q;
  assign o_qbar = ~r_q;

endmodule
`default_nettype wire

// File: rtl/tff_mod_counter.sv
`default_nettype none
// ============================================================================
// Module : tff_mod_counter
// Brief  : Modulo-MODULUS up/down counter realised as a row of toggle cells.
//          The next count is computed here and turned into per-bit toggle
//          enables (current ^ next); the cells alone hold the count.
//          clk, reset : clock and asynchronous active-high clear
//          bus        : en/up/load/load_val in; count/count_bar/tc/wrap/err out
// Rev    : 1.0  initial release
// ============================================================================
module tff_mod_counter
  import tff_mod_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  wire logic         clk,
  input  wire logic         reset,
  tff_mod_counter_if.slave  bus
);

  if (!modulus_is_legal(WIDTH, longint'(MODULUS))) begin : g_bad_modulus
    $error("tff_mod_counter: MODULUS out of range for WIDTH");
  end

  localparam logic [WIDTH-1:0] c_TERM = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2**WIDTH is representable in the load check.
  localparam logic [WIDTH:0]   c_MOD  = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] w_count;
  logic [WIDTH-1:0] w_count_bar;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_t;
  logic             w_wrap_evt;
  logic             w_err_next;
  logic             w_at_term;
  logic             w_at_zero;
  logic             r_wrap;
  logic             r_err;

  assign w_at_term = (w_count == c_TERM);
  assign w_at_zero = (w_count == '0);

  always_comb begin
    w_next     = w_count;
    w_wrap_evt = 1'b0;
    w_err_next = r_err;
    if (bus.load) begin
      if ({1'b0, bus.load_val} < c_MOD) begin
        w_next     = bus.load_val;
        w_err_next = 1'b0;
      end else begin
        w_next     = '0;
        w_err_next = 1'b1;
      end
    end else if (bus.en) begin
      if (bus.up == DIR_UP) begin
        // Wrap at MODULUS-1 rather than on binary overflow, so a
        // non-power-of-two modulus never enters an unused code.
        if (w_at_term) begin
          w_next     = '0;
          w_wrap_evt = 1'b1;
        end else begin
          w_next = w_count + 1'b1;
        end
      end else begin
        if (w_at_zero) begin
          w_next     = c_TERM;
          w_wrap_evt = 1'b1;
        end else begin
          w_next = w_count - 1'b1;
        end
      end
    end
  end

  // A bit toggles exactly where the current and next counts differ.
  assign w_t = w_count ^ w_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cells
    T_flipflop u_cell (
      .clk    (clk),
      .reset  (reset),
      .i_t    (w_t[i]),
      .o_q    (w_count[i]),
      .o_qbar (w_count_bar[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_wrap <= w_wrap_evt;
      r_err  <= w_err_next;
    end
  end

  assign bus.count     = w_count;
  assign bus.count_bar = w_count_bar;
  // Cascade enable: valid in the cycle before the wrapping edge.
  assign bus.tc        = bus.en & ~bus.load &
                         ((bus.up == DIR_UP) ? w_at_term : w_at_zero);
  assign bus.wrap      = r_wrap;
  assign bus.err       = r_err;

endmodule
`default_nettype wire
